// File: rtl/pci_target_mem.sv
// pci_target_mem
//   PCI memory-space target backed by a small word-addressed RAM window.
//   Claims memory read/write commands whose address falls inside the
//   2^ADDR_BITS-word window at BASE_ADDR. Fast DEVSEL decode, zero-wait
//   writes, a one-cycle AD turnaround on reads, and a disconnect-with-data
//   on the last word of the window (bursts never wrap).
//
// Ports
//   PCI_CLK   in    bus clock, all logic on the rising edge
//   RESET     in    synchronous, active-high reset (memory is not cleared)
//   FRAME_n   in    initiator frame
//   IRDY_n    in    initiator ready
//   C_BE      in    command (address phase) / active-low byte enables (data)
//   IDSEL     in    unused, there is no configuration space
//   AD        inout address/data, driven only while presenting read data
//   PAR       inout even parity over AD and C_BE, driven one clock after AD on reads
//   DEVSEL_n  inout target select
//   TRDY_n    inout target ready
//   STOP_n    inout target stop
module pci_target_mem #(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int unsigned ADDR_BITS = 4
) (
  input  logic        PCI_CLK,
  input  logic        RESET,
  input  logic        FRAME_n,
  input  logic        IRDY_n,
  input  logic [3:0]  C_BE,
  input  logic        IDSEL,
  inout  wire  [31:0] AD,
  inout  wire         PAR,
  inout  wire         DEVSEL_n,
  inout  wire         TRDY_n,
  inout  wire         STOP_n
);

  localparam int unsigned          WORDS     = 1 << ADDR_BITS;
  localparam logic [31:0]          WIN_MASK  = (32'd1 << (ADDR_BITS + 2)) - 32'd1;
  localparam logic [ADDR_BITS-1:0] LAST_WORD = '1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BUSY,
    ST_WDATA,
    ST_RWAIT,
    ST_RDATA,
    ST_TURN
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [ADDR_BITS-1:0] word;
  logic                 disc;       // STOP_n held after the last-word transfer
  logic                 seen_idle;  // previous edge was an idle edge
  logic [31:0]          mem [WORDS];
  logic                 par_q;
  logic                 par_oe;

  logic        cmd_read;
  logic        cmd_write;
  logic        addr_hit;
  logic        addr_phase;
  logic        xfer;
  logic        last_word;

  logic        tgt_oe;
  logic        devsel_d;
  logic        trdy_d;
  logic        stop_d;
  logic        ad_oe;
  logic [31:0] ad_out;

  logic unused_idsel;
  assign unused_idsel = IDSEL;

  // Address decode and transfer qualification
  always_comb begin
    cmd_read   = (C_BE == 4'b0110) || (C_BE == 4'b1100) || (C_BE == 4'b1110);
    cmd_write  = (C_BE == 4'b0111) || (C_BE == 4'b1111);
    addr_hit   = (cmd_read || cmd_write) && ((AD & ~WIN_MASK) == BASE_ADDR);
    // An address phase may also start on the edge that leaves TURN.
    addr_phase = !FRAME_n && (((state == ST_IDLE) && seen_idle) || (state == ST_TURN));
    xfer       = ((state == ST_WDATA) || (state == ST_RDATA)) && !disc && !IRDY_n;
    last_word  = (word == LAST_WORD);
  end

  // State register
  always_ff @(posedge PCI_CLK) begin
    if (RESET) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_TURN: begin
        if (addr_phase) begin
          if (!addr_hit) begin
            state_nxt = ST_BUSY;
          end else if (cmd_write) begin
            state_nxt = ST_WDATA;
          end else begin
            state_nxt = ST_RWAIT;
          end
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (FRAME_n && IRDY_n) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_RWAIT: state_nxt = ST_RDATA;
      ST_WDATA, ST_RDATA: begin
        if (disc ? FRAME_n : (xfer && FRAME_n)) begin
          state_nxt = ST_TURN;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Word counter, disconnect flag, idle tracking and read parity
  always_ff @(posedge PCI_CLK) begin
    if (RESET) begin
      word      <= '0;
      disc      <= 1'b0;
      seen_idle <= 1'b0;
      par_oe    <= 1'b0;
      par_q     <= 1'b0;
    end else begin
      seen_idle <= FRAME_n && IRDY_n;
      // Parity trails the AD value it covers by one clock, and is released
      // one clock after AD.
      par_oe    <= ad_oe;
      par_q     <= ^{ad_out, C_BE};
      if (addr_phase) begin
        word <= AD[ADDR_BITS+1:2];
        disc <= 1'b0;
      end else if (xfer && !FRAME_n) begin
        // At the window end the counter holds and the burst is disconnected.
        if (last_word) begin
          disc <= 1'b1;
        end else begin
          word <= word + 1'b1;
        end
      end
    end
  end

  // Write port with per-lane byte enables; contents survive reset
  always_ff @(posedge PCI_CLK) begin
    if (!RESET && (state == ST_WDATA) && xfer) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (!C_BE[i]) begin
          mem[word][8*i +: 8] <= AD[8*i +: 8];
        end
      end
    end
  end

  // Output logic
  always_comb begin
    tgt_oe   = 1'b0;
    devsel_d = 1'b1;
    trdy_d   = 1'b1;
    stop_d   = 1'b1;
    case (state)
      ST_RWAIT: begin
        tgt_oe   = 1'b1;
        devsel_d = 1'b0;
      end
      ST_WDATA, ST_RDATA: begin
        tgt_oe   = 1'b1;
        devsel_d = 1'b0;
        trdy_d   = disc;
        stop_d   = !(disc || (last_word && !FRAME_n));
      end
      ST_TURN: begin
        tgt_oe = 1'b1;
      end
      default: begin
        tgt_oe = 1'b0;
      end
    endcase
    ad_oe  = (state == ST_RDATA);
    ad_out = mem[word];
  end

  assign DEVSEL_n = tgt_oe ? devsel_d : 1'bz;
  assign TRDY_n   = tgt_oe ? trdy_d   : 1'bz;
  assign STOP_n   = tgt_oe ? stop_d   : 1'bz;
  assign AD       = ad_oe  ? ad_out   : 'z;
  assign PAR      = par_oe ? par_q    : 1'bz;

endmodule

// File: doc/pci_target_mem.md
PCI_TARGET_MEM -- requirements
Module: pci_target_mem

Interface
REQ-001 The block SHALL have parameter BASE_ADDR, default 32'h8000_0000, meaning the memory-space base address; it SHALL be aligned to the window size.
REQ-002 The block SHALL have parameter ADDR_BITS, default 4, meaning log2 of the window size in 32-bit words (16 words, 64 bytes).
REQ-003 The block SHALL have the following ports:
- PCI_CLK  input  1  bus clock; all logic on the rising edge
- RESET  input  1  synchronous, active-high reset
- FRAME_n  input  1  initiator frame
- IRDY_n  input  1  initiator ready
- C_BE  input  4  command (address phase) / active-low byte enables (data phase)
- IDSEL  input  1  ignored; no configuration space
- AD  inout  32  address/data
- PAR  inout  1  even parity over AD[31:0] and C_BE[3:0]
- DEVSEL_n  inout  1  target-driven select
- TRDY_n  inout  1  target-driven ready
- STOP_n  inout  1  target-driven stop

Function
REQ-004 Supported commands SHALL be 4'b0110 MemRead, 4'b1100 MemReadMultiple, 4'b1110 MemReadLine, 4'b0111 MemWrite and 4'b1111 MemWriteInvalidate; all other commands SHALL be ignored.
REQ-005 The address phase SHALL be the first edge with FRAME_n=0 after an idle edge (FRAME_n=1, IRDY_n=1); AD and C_BE SHALL be latched on that edge.
REQ-006 A hit SHALL be a supported command with (AD & ~(2^(ADDR_BITS+2)-1)) == BASE_ADDR; AD[1:0] SHALL be ignored.
REQ-007 The state machine SHALL have the states IDLE, BUSY, WDATA, RWAIT, RDATA and TURN.
REQ-008 Transitions from IDLE:
- hit write -> WDATA
- hit read -> RWAIT
- miss -> BUSY
- BUSY -> IDLE when FRAME_n=1 and IRDY_n=1 are seen on the same edge.
REQ-009 DEVSEL_n SHALL be driven 0 starting on the edge after the address phase (fast decode) and held until the final transfer.
REQ-010 Writes: TRDY_n SHALL be 0 from the same edge as DEVSEL_n (zero wait states); on each edge with IRDY_n=0 and TRDY_n=0, each byte lane with C_BE[i]=0 SHALL be written to mem[word] and word SHALL increment.
REQ-011 Reads: RWAIT SHALL last exactly one cycle (AD turnaround); in RDATA, AD SHALL be driven with mem[word] and TRDY_n SHALL be 0; word SHALL advance on each transfer, and the next word SHALL be presented on the following edge.
REQ-012 PAR SHALL be driven by the target on reads only, one clock after the AD value it covers, and released one clock after AD is released.
REQ-013 A transfer with FRAME_n=1 (last data phase) SHALL move the machine to TURN.
REQ-014 When word is the last word of the window and FRAME_n=0, STOP_n SHALL be driven 0 together with TRDY_n (disconnect-with-data); after that transfer, TRDY_n SHALL be 1 and STOP_n SHALL stay 0 until FRAME_n=1, then the machine SHALL go to TURN.
REQ-015 The word counter SHALL never wrap within a burst.
REQ-016 TURN SHALL drive DEVSEL_n, TRDY_n and STOP_n to 1 for exactly one cycle, then release them to z and return to IDLE.
REQ-017 TURN SHALL release AD immediately.
REQ-018 When FRAME_n=0 on the edge leaving TURN, the machine SHALL treat that edge as a new address phase.
REQ-019 In IDLE and BUSY, all inout signals SHALL be z.
REQ-020 AD SHALL never be driven except in RDATA.
REQ-021 Memory contents SHALL be undefined until written.
REQ-022 Bit-exact parity SHALL be the XOR of AD[31:0] and C_BE[3:0]; address parity checking and PERR/SERR SHALL NOT be implemented.

Reset
REQ-023 While RESET=1 on a clock edge, the state SHALL become IDLE and the word counter 0.
REQ-024 After such an edge, DEVSEL_n, TRDY_n, STOP_n, AD and PAR SHALL be z, even mid-burst; there SHALL be no TURN cycle.
REQ-025 Reset SHALL NOT clear the memory.
REQ-026 After reset, the block SHALL ignore the bus until an idle edge has been observed.

Verification
REQ-027 The bench SHALL cover: write BASE_ADDR+0x8, cmd 0111, single phase, data 32'hDEADBEEF, C_BE=0000 -> DEVSEL_n and TRDY_n =0 at address edge+1; transfer on that edge; mem[2]=32'hDEADBEEF; TURN drives 1s for one cycle, then z.
REQ-028 The bench SHALL cover: byte-enable write of 32'h11223344 to word 2 with C_BE=1010 -> mem[2]=32'hDE22BE44.
REQ-029 The bench SHALL cover: read burst cmd 0110 from BASE_ADDR+0x0, 3 phases, with IRDY_n=1 inserted before phase 2 -> TRDY_n=0 at address edge+2; data mem[0], mem[1], mem[2] in order; PAR correct one clock later; word held during the IRDY stall.
REQ-030 The bench SHALL cover: read burst starting at word 14 with FRAME_n held low -> two transfers; STOP_n=0 with TRDY_n=0 on the word-15 transfer; TRDY_n=1 and STOP_n=0 until FRAME_n=1; then TURN.
REQ-031 The bench SHALL cover: miss BASE_ADDR+0x40, and cmd 0010 (IO read) at BASE_ADDR -> no target signal ever leaves z for either transaction; a following hit after the idle edge is claimed normally.
REQ-032 The bench SHALL cover: RESET=1 asserted during the RDATA of a 4-phase read -> all outputs z on the next edge; state IDLE; memory contents unchanged when read back later.
